// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a byte stream (count, N words, XOR checksum),
// writes each word into instruction memory and holds the CPU while the load runs.
module imem_loader #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, COUNT, HI, LO, WRITE, CHK, DONE, ERR
  } state_t;

  state_t state, state_nx;

  // One spare bit so N = DEPTH fits and the word index can never wrap.
  logic [ADDR_W:0] n_q;
  logic [ADDR_W:0] idx_q;
  logic [7:0]      hi_q;
  logic [7:0]      xor_q;

  logic accept;
  logic count_ok;

  assign accept   = byte_valid && byte_ready;
  assign count_ok = (byte_data != 8'd0) && (32'(byte_data) <= DEPTH);

  // Status outputs decode straight from state, so an async reset clears them at once.
  always_comb begin
    byte_ready = (state == COUNT) || (state == HI) || (state == LO) || (state == CHK);
    we         = (state == WRITE);
    cpu_hold   = (state != IDLE);
    done       = (state == DONE);
    err        = (state == ERR);
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = COUNT;
      COUNT: if (accept) state_nx = count_ok ? HI : ERR;
      HI:    if (accept) state_nx = LO;
      LO:    if (accept) state_nx = WRITE;
      WRITE: state_nx = (idx_q == n_q - 1'b1) ? CHK : HI;
      CHK:   if (accept) state_nx = (byte_data == xor_q) ? DONE : ERR;
      DONE:  state_nx = IDLE;
      ERR:   if (start) state_nx = COUNT;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // waddr/wdata are loaded on the low-byte accept, are valid during WRITE and
  // simply hold afterwards; a reset before that edge drops a half-built word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q   <= '0;
      idx_q <= '0;
      hi_q  <= '0;
      xor_q <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      unique case (state)
        COUNT: if (accept && count_ok) begin
          n_q   <= byte_data[ADDR_W:0];
          idx_q <= '0;
          xor_q <= byte_data;
        end
        HI: if (accept) begin
          hi_q  <= byte_data;
          xor_q <= xor_q ^ byte_data;
        end
        LO: if (accept) begin
          wdata <= {hi_q, byte_data};
          waddr <= idx_q[ADDR_W-1:0];
          xor_q <= xor_q ^ byte_data;
        end
        WRITE: idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized program streams compared against
// a stream-level model of which words must land in memory and how the load ends.
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Program image for the current load (the reference model's memory contents).
  logic [15:0] prog [DEPTH];

  // Observed memory writes and pulses, gathered away from the active edge.
  logic [ADDR_W+15:0] wr_q[$];
  int done_cnt   = 0;
  int ready_viol = 0;

  always @(negedge clk) begin
    if (we) wr_q.push_back({waddr, wdata});
    if (we && byte_ready) ready_viol++;
    if (done) done_cnt++;
  end

  // Checksum of a stream: XOR of the count byte and every word byte.
  function automatic logic [7:0] stream_xor(input int n);
    logic [7:0] bytes[$];
    logic [7:0] x;
    bytes.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      bytes.push_back(prog[i][15:8]);
      bytes.push_back(prog[i][7:0]);
    end
    x = 8'h00;
    foreach (bytes[k]) x ^= bytes[k];
    return x;
  endfunction

  task automatic clear_monitor();
    wr_q.delete();
    done_cnt   = 0;
    ready_viol = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offer one byte after an optional idle gap; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int  gaps;
    int  budget;
    bit  acc;
    gaps   = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    acc    = 1'b0;
    budget = 0;
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    while (!acc) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      acc        = byte_ready;
      @(posedge clk);
      budget++;
      if (!acc && budget > 40) begin
        checks++;
        failures++;
        $display("FAIL send_byte_timeout: byte %02h not accepted within 40 cycles", b);
        break;
      end
    end
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      send_byte(prog[i][15:8], gap_max);
      send_byte(prog[i][7:0], gap_max);
    end
  endtask

  task automatic randomize_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({byte_ready, we, waddr, wdata, cpu_hold, done, err} !== '0) begin
      failures++;
      $display("FAIL reset_state: got ready=%b we=%b waddr=%0d wdata=%04h hold=%b done=%b err=%b, want all 0",
               byte_ready, we, waddr, wdata, cpu_hold, done, err);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    clear_monitor();
    prog[0] = 16'h1123;
    prog[1] = 16'h2234;
    pulse_start();
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_hold_after_start: got hold=%b ready=%b, want 1 1", cpu_hold, byte_ready);
    end
    send_byte(8'h02, 0);
    send_words(2, 0);
    send_byte(8'h26, 0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: got done=%b hold=%b err=%b, want 1 1 0", done, cpu_hold, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL basic_after_done: got done=%b hold=%b, want 0 0", done, cpu_hold);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_q.size() != 2 || wr_q[0] !== {4'd0, 16'h1123} || wr_q[1] !== {4'd1, 16'h2234}) begin
      failures++;
      $display("FAIL basic_writes: got %0d writes first=%05h second=%05h, want 2 writes 01123 12234",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, (wr_q.size() > 1) ? wr_q[1] : '0);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL basic_done_count: got %0d, want 1", done_cnt);
    end
  endtask

  task automatic test_bad_checksum();
    apply_reset();
    clear_monitor();
    prog[0] = 16'h1123;
    prog[1] = 16'h2234;
    pulse_start();
    send_byte(8'h02, 0);
    send_words(2, 0);
    send_byte(8'h27, 0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL badchk_err: got err=%b done=%b hold=%b, want 1 0 1", err, done, cpu_hold);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || wr_q.size() != 2 || done_cnt != 0) begin
      failures++;
      $display("FAIL badchk_sticky: got err=%b hold=%b writes=%0d dones=%0d, want 1 1 2 0",
               err, cpu_hold, wr_q.size(), done_cnt);
    end
    pulse_start();
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL badchk_restart: got err=%b ready=%b, want 0 1", err, byte_ready);
    end
  endtask

  task automatic test_bad_count();
    logic [7:0] bad [2];
    bad[0] = 8'h00;
    bad[1] = 8'(DEPTH + 1);
    apply_reset();
    clear_monitor();
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      send_byte(bad[k], 0);
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || byte_ready !== 1'b0) begin
        failures++;
        $display("FAIL badcount_%02h: got err=%b ready=%b, want 1 0", bad[k], err, byte_ready);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_q.size() != 0) begin
      failures++;
      $display("FAIL badcount_writes: got %0d writes, want 0", wr_q.size());
    end
  endtask

  // Full load with random gaps, compared word by word against the program image.
  task automatic run_and_check(input string name, input int n, input int gap_max);
    int bad_words;
    clear_monitor();
    pulse_start();
    send_byte(8'(n), gap_max);
    send_words(n, gap_max);
    send_byte(stream_xor(n), gap_max);
    repeat (4) @(negedge clk);
    bad_words = 0;
    for (int i = 0; i < wr_q.size() && i < n; i++)
      if (wr_q[i] !== {ADDR_W'(i), prog[i]}) bad_words++;
    checks++;
    if (wr_q.size() != n || bad_words != 0) begin
      failures++;
      $display("FAIL %s_writes: got %0d writes (%0d wrong), want %0d in order", name, wr_q.size(), bad_words, n);
    end
    checks++;
    if (done_cnt != 1 || err !== 1'b0 || cpu_hold !== 1'b0 || ready_viol != 0) begin
      failures++;
      $display("FAIL %s_end: got dones=%0d err=%b hold=%b ready_in_write=%0d, want 1 0 0 0",
               name, done_cnt, err, cpu_hold, ready_viol);
    end
  endtask

  task automatic test_full_gaps();
    apply_reset();
    randomize_prog();
    run_and_check("full16", DEPTH, 3);
  endtask

  task automatic test_reset_midload();
    apply_reset();
    clear_monitor();
    randomize_prog();
    prog[0][15:8] = 8'hA5;
    pulse_start();
    send_byte(8'h02, 0);
    send_words(1, 0);
    send_byte(prog[1][15:8], 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({byte_ready, we, waddr, wdata, cpu_hold, done, err} !== '0) begin
      failures++;
      $display("FAIL midreset_async: got ready=%b we=%b waddr=%0d wdata=%04h hold=%b done=%b err=%b, want all 0",
               byte_ready, we, waddr, wdata, cpu_hold, done, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {ADDR_W'(0), prog[0]}) begin
      failures++;
      $display("FAIL midreset_writes: got %0d writes, want only word 0 (%04h)", wr_q.size(), prog[0]);
    end
    randomize_prog();
    run_and_check("after_reset", 3, 1);
  endtask

  task automatic test_start_in_hi();
    int bad_words;
    apply_reset();
    clear_monitor();
    randomize_prog();
    pulse_start();
    send_byte(8'h03, 0);
    pulse_start();
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL start_in_hi_state: got ready=%b err=%b hold=%b, want 1 0 1", byte_ready, err, cpu_hold);
    end
    send_words(3, 0);
    send_byte(stream_xor(3), 0);
    repeat (4) @(negedge clk);
    bad_words = 0;
    for (int i = 0; i < wr_q.size() && i < 3; i++)
      if (wr_q[i] !== {ADDR_W'(i), prog[i]}) bad_words++;
    checks++;
    if (wr_q.size() != 3 || bad_words != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL start_in_hi_load: got writes=%0d wrong=%0d dones=%0d, want 3 0 1", wr_q.size(), bad_words, done_cnt);
    end
  endtask

  task automatic test_random_loads();
    for (int t = 0; t < 6; t++) begin
      randomize_prog();
      run_and_check($sformatf("rand%0d", t), int'($urandom_range(DEPTH, 1)), int'($urandom_range(2, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_bad_count();
    test_full_gaps();
    test_reset_midload();
    test_start_in_hi();
    test_random_loads();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 4, instruction-memory address width; depth = 2^ADDR_W words (16 at default); legal range 1..7.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  single-cycle request to begin a program load.
REQ-005 Port: byte_valid  input  1  byte_data holds a valid stream byte.
REQ-006 Port: byte_data  input  8  program stream byte.
REQ-007 Port: byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 Port: we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port: waddr  output  ADDR_W  instruction-memory write address.
REQ-010 Port: wdata  output  16  instruction word: [opcode 4][rd 4][rs1 4][rs2/imm 4].
REQ-011 Port: cpu_hold  output  1  holds the pipeline CPU (PC and pipeline registers frozen) while a load is in progress.
REQ-012 Port: done  output  1  one-cycle pulse on successful load; CPU uses it to clear PC to 0.
REQ-013 Port: err  output  1  sticky load-failure flag.

Function
REQ-014 Stream format SHALL be: count byte N, then N words as high byte then low byte, then one checksum byte equal to the XOR of all preceding bytes, including N.
REQ-015 A byte SHALL be accepted on a rising edge where byte_valid=1 and byte_ready=1; otherwise the byte is not consumed.
REQ-016 The FSM SHALL have the states IDLE, COUNT, HI, LO, WRITE, CHK, DONE and ERR.
REQ-017 byte_ready SHALL be 1 only in COUNT, HI, LO and CHK.
REQ-018 cpu_hold SHALL be 1 in every state except IDLE.
REQ-019 IDLE: start=1 -> COUNT; start SHALL be ignored in all other states except ERR.
REQ-020 COUNT: on an accepted byte, a value of 1..2^ADDR_W SHALL latch N, clear the word index to 0, seed the XOR with the byte and go to HI; a value of 0 or greater than 2^ADDR_W SHALL go to ERR.
REQ-021 HI: on an accepted byte, SHALL latch the high byte, fold it into the XOR and go to LO.
REQ-022 LO: on an accepted byte, SHALL latch the low byte, fold it into the XOR and go to WRITE.
REQ-023 WRITE: we=1 for exactly one cycle with waddr=index and wdata={hi,lo}, i.e. the cycle after the low-byte accept; the index then increments and the FSM goes to CHK if the index equals N-1, else to HI.
REQ-024 The index SHALL never wrap; at most 2^ADDR_W writes per load, with waddr running 0..N-1 in order.
REQ-025 CHK: on an accepted byte equal to the running XOR -> DONE; on a mismatch -> ERR.
REQ-026 DONE: done=1 and cpu_hold=1 for exactly one cycle, then IDLE.
REQ-027 ERR: err=1 and cpu_hold=1; start=1 SHALL clear err and go to COUNT; no writes occur in ERR.
REQ-028 we SHALL be 0 in every state except WRITE; waddr and wdata SHALL hold their last values outside WRITE.
REQ-029 Words already written before an ERR SHALL remain in memory, with no rollback.

Reset
REQ-030 rst=1 SHALL immediately force IDLE with byte_ready=0, we=0, waddr=0, wdata=0, cpu_hold=0, done=0, err=0, and N, index and XOR cleared.
REQ-031 A reset during a load SHALL abandon it with no further writes; a partially latched word SHALL NOT be written.

Verification
REQ-032 start, then bytes 02 11 23 22 34 26 -> we at waddr0=0x1123, then waddr1=0x2234; done pulse one cycle after the 0x26 accept; cpu_hold high from the cycle after start until the done cycle.
REQ-033 Same stream with checksum 0x27 -> both writes occur, err=1, no done, cpu_hold stays 1; a subsequent start clears err.
REQ-034 Count byte 0x00, and separately 0x11 (ADDR_W=4) -> ERR on the next cycle, zero writes.
REQ-035 16-word load with random byte_valid gaps -> exactly 16 writes at waddr 0..15, byte_ready=0 during each WRITE cycle, no byte lost or duplicated.
REQ-036 rst asserted after the HI byte of word 1 -> all outputs reset asynchronously, no write for word 1, and the next start performs a fresh load.
REQ-037 start pulsed in HI -> ignored, and the load completes normally.
